// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - frame constants, FSM state types and the CRC8 helper shared with the RX parser
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE           = 8'h5A;
  localparam int         DEF_MAX_DATA_BYTES = 64;
  localparam logic [7:0] CRC_POLY           = 8'h07;
  localparam logic [7:0] CRC_INIT           = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_STAT,
    ST_CMD,
    ST_ADDR,
    ST_FETCH,
    ST_DATA,
    ST_CRC,
    ST_FINISH
  } frame_state_t;

  // IS_PULSE is the single cycle tx_start is high; IS_ISSUE waits out tx_busy.
  typedef enum logic [2:0] {
    IS_IDLE,
    IS_ISSUE,
    IS_PULSE,
    IS_CONFIRM,
    IS_WAIT
  } issue_state_t;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte_issuer.sv
// rtl/uart_tx_byte_issuer.sv - one-byte issue/confirm/wait handshake towards the UART transmitter
module uart_tx_byte_issuer
  import uart_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] send_byte,
  output logic       accepted,
  output logic       done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_done
);

  issue_state_t state, state_nx;
  logic         load;
  logic         start_d;
  logic [7:0]   data_d;

  // A new byte may be loaded while idle or on the very cycle the previous one completes.
  assign load = send && ((state == IS_IDLE) || ((state == IS_WAIT) && tx_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IS_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nx;
      tx_start <= start_d;
      tx_data  <= data_d;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IS_IDLE:    state_nx = IS_IDLE;
      IS_ISSUE:   if (!tx_busy) state_nx = IS_PULSE;
      IS_PULSE:   state_nx = IS_CONFIRM;
      // A refusal leaves tx_busy low, so the re-pulse can go out immediately.
      IS_CONFIRM: state_nx = tx_busy ? IS_WAIT : IS_PULSE;
      IS_WAIT:    if (tx_done) state_nx = IS_IDLE;
      default:    state_nx = IS_IDLE;
    endcase
    if (load) begin
      state_nx = tx_busy ? IS_ISSUE : IS_PULSE;
    end
  end

  always_comb begin
    start_d  = (state_nx == IS_PULSE);
    data_d   = load ? send_byte : tx_data;
    accepted = (state == IS_CONFIRM) && tx_busy;
    done     = (state == IS_WAIT) && tx_done;
  end

endmodule

// File: rtl/uart_tx_frame_builder.sv
// rtl/uart_tx_frame_builder.sv - serialises SOF/STATUS/CMD/ADDR/payload/CRC8 frames into the UART transmitter
module uart_tx_frame_builder
  import uart_frame_pkg::*;
#(
  parameter int MAX_DATA_BYTES = DEF_MAX_DATA_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        frame_ready,
  input  logic [7:0]  status,
  input  logic [7:0]  cmd,
  input  logic [31:0] addr,
  input  logic        include_addr,
  input  logic [6:0]  data_len,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        frame_done,
  output logic        len_error
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_DATA_BYTES);

  frame_state_t state, state_nx;

  logic [7:0]  status_q, cmd_q, crc_q;
  logic [31:0] addr_q;
  logic        inc_addr_q;
  logic [6:0]  len_q, cnt_q;
  logic [1:0]  addr_idx, addr_idx_nx;

  logic        send, accepted, done;
  logic [7:0]  send_byte;
  logic        start_ok, take_data, fold_crc;
  logic        frame_ready_d, data_ready_d, frame_done_d, len_error_d;

  assign start_ok    = frame_start && (data_len <= MAX_LEN);
  assign take_data   = (state == ST_FETCH) && data_valid && data_ready;
  assign addr_idx_nx = addr_idx + 2'd1;
  assign fold_crc    = accepted && (state inside {ST_STAT, ST_CMD, ST_ADDR, ST_DATA});

  uart_tx_byte_issuer u_issuer (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .send_byte (send_byte),
    .accepted  (accepted),
    .done      (done),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_ready <= 1'b1;
      data_ready  <= 1'b0;
      frame_done  <= 1'b0;
      len_error   <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_ready <= frame_ready_d;
      data_ready  <= data_ready_d;
      frame_done  <= frame_done_d;
      len_error   <= len_error_d;
    end
  end

  // Each transition into a sending state also hands the next byte to the issuer.
  always_comb begin
    state_nx  = state;
    send      = 1'b0;
    send_byte = 8'h00;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nx  = ST_SOF;
          send      = 1'b1;
          send_byte = SOF_BYTE;
        end
      end
      ST_SOF: begin
        if (done) begin
          state_nx  = ST_STAT;
          send      = 1'b1;
          send_byte = status_q;
        end
      end
      ST_STAT: begin
        if (done) begin
          state_nx  = ST_CMD;
          send      = 1'b1;
          send_byte = cmd_q;
        end
      end
      ST_CMD, ST_ADDR: begin
        if (done) begin
          if ((state == ST_CMD) && inc_addr_q) begin
            state_nx  = ST_ADDR;
            send      = 1'b1;
            send_byte = addr_q[7:0];
          end else if ((state == ST_ADDR) && (addr_idx != 2'd3)) begin
            state_nx  = ST_ADDR;
            send      = 1'b1;
            send_byte = addr_q[{addr_idx_nx, 3'b000} +: 8];
          end else if (len_q != 7'd0) begin
            state_nx = ST_FETCH;
          end else begin
            state_nx  = ST_CRC;
            send      = 1'b1;
            send_byte = crc_q;
          end
        end
      end
      ST_FETCH: begin
        if (take_data) begin
          state_nx  = ST_DATA;
          send      = 1'b1;
          send_byte = data_in;
        end
      end
      ST_DATA: begin
        if (done) begin
          if (cnt_q == len_q) begin
            state_nx  = ST_CRC;
            send      = 1'b1;
            send_byte = crc_q;
          end else begin
            state_nx = ST_FETCH;
          end
        end
      end
      ST_CRC:    if (done) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_ready_d = (state_nx == ST_IDLE);
    data_ready_d  = (state_nx == ST_FETCH);
    frame_done_d  = (state_nx == ST_FINISH);
    len_error_d   = (state == ST_IDLE) && frame_start && (data_len > MAX_LEN);
  end

  // The issuer holds the accepted byte on tx_data, so the CRC folds it straight from there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= 8'h00;
      cmd_q      <= 8'h00;
      addr_q     <= 32'h0;
      inc_addr_q <= 1'b0;
      len_q      <= 7'd0;
      cnt_q      <= 7'd0;
      addr_idx   <= 2'd0;
      crc_q      <= CRC_INIT;
    end else begin
      if ((state == ST_IDLE) && start_ok) begin
        status_q   <= status;
        cmd_q      <= cmd;
        addr_q     <= addr;
        inc_addr_q <= include_addr;
        len_q      <= data_len;
        cnt_q      <= 7'd0;
        addr_idx   <= 2'd0;
        crc_q      <= CRC_INIT;
      end
      if (take_data) begin
        cnt_q <= cnt_q + 7'd1;
      end
      if ((state == ST_ADDR) && done) begin
        addr_idx <= addr_idx_nx;
      end
      if (fold_crc) begin
        crc_q <= crc8_update(crc_q, tx_data);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_builder.sv
// tb/tb_uart_tx_frame_builder.sv - directed bench with a byte-list frame model and transmitter responder
module tb_uart_tx_frame_builder;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, frame_ready;
  logic [7:0]  status, cmd;
  logic [31:0] addr;
  logic        include_addr;
  logic [6:0]  data_len;
  logic [7:0]  data_in;
  logic        data_valid, data_ready;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, tx_done, frame_done, len_error;

  always #5 clk = ~clk;

  uart_tx_frame_builder dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_ready  (frame_ready),
    .status       (status),
    .cmd          (cmd),
    .addr         (addr),
    .include_addr (include_addr),
    .data_len     (data_len),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .frame_done   (frame_done),
    .len_error    (len_error)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pay_q[$];

  logic cts = 1'b1;
  int   busy_cnt = 0;
  int   cyc = 0;
  int   last_ref = -1;
  int   refused = 0;
  int   done_count = 0;
  int   len_err_count = 0;
  int   hold = 0;
  int   hold_bad = 0;
  bit   hold_started = 0;
  bit   consuming = 0;

  logic [7:0] lit1 [11] = '{8'h5A, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
  logic [7:0] lit2 [4]  = '{8'h5A, 8'h00, 8'h00, 8'h00};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Bit-serial CRC8 (poly 0x07): feed each data bit MSB first into the register's top bit.
  function automatic logic [7:0] m_crc_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic expect_frame(input logic [7:0] st, input logic [7:0] cm, input logic [31:0] ad,
                              input logic inc, input int len);
    logic [7:0] body[$];
    logic [7:0] c;
    body.push_back(st);
    body.push_back(cm);
    if (inc) for (int i = 0; i < 4; i++) body.push_back(ad[8*i +: 8]);
    for (int i = 0; i < len; i++) body.push_back(pay_q[i]);
    c = 8'h00;
    foreach (body[i]) c = m_crc_byte(c, body[i]);
    exp_q.push_back(8'h5A);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(c);
  endtask

  task automatic start_frame(input logic [7:0] st, input logic [7:0] cm, input logic [31:0] ad,
                             input logic inc, input logic [6:0] len);
    @(posedge clk); #1;
    status = st; cmd = cm; addr = ad; include_addr = inc; data_len = len;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("sof_latency_start", tx_start, 1);
    check("sof_latency_data", tx_data, 8'h5A);
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_bytes_sent", 32'(got_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (done_count == n0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_frame_done", 32'(done_count > n0), 1);
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_once", done_count, n0 + 1);
    check("all_bytes_sent", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_frame_ready", frame_ready, 1);
    check("rst_data_ready", data_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_len_error", len_error, 0);
    check("rst_tx_data", tx_data, 8'h00);
  endtask

  // Transmitter responder: accepts a start when CTS is asserted, busy 3 cycles, then tx_done.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin tx_busy = 1'b0; tx_done = 1'b1; end
        end else if (tx_start && cts) begin
          tx_busy = 1'b1; busy_cnt = 3;
        end
      end
    end
  end

  // Payload source, with an optional hold-off once data_ready first appears.
  initial begin
    data_valid = 1'b0;
    data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        data_valid = 1'b0; consuming = 0;
      end else begin
        if (consuming) begin
          void'(pay_q.pop_front());
          consuming = 0; data_valid = 1'b0;
        end
        if (data_ready && hold > 0) hold_started = 1;
        if (hold_started && hold > 0) begin
          if (!data_ready || tx_start) hold_bad++;
          hold--;
          if (hold == 0) hold_started = 0;
        end else if (data_ready && pay_q.size() > 0) begin
          data_valid = 1'b1; data_in = pay_q[0]; consuming = 1;
        end
      end
    end
  end

  // Compare process: every issued byte against the model's expected byte list.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (tx_start) begin
        if (cts) begin
          got_q.push_back(tx_data);
          check("tx_byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            check("tx_byte", tx_data, exp_q[0]);
            void'(exp_q.pop_front());
          end
          last_ref = -1;
        end else begin
          refused++;
          if (exp_q.size() != 0) check("refused_byte", tx_data, exp_q[0]);
          if (last_ref >= 0) check("retry_spacing", cyc - last_ref, 2);
          last_ref = cyc;
        end
      end
      if (frame_done) begin
        done_count++;
        check("done_after_last_byte", exp_q.size(), 0);
      end
      if (len_error) len_err_count++;
    end
  end

  initial begin
    logic [7:0] c;
    int n0, g0;
    rst = 1'b1; frame_start = 1'b0; status = 8'h00; cmd = 8'h00; addr = 32'h0;
    include_addr = 1'b0; data_len = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    c = 8'h00;
    for (int i = 0; i < 9; i++) c = m_crc_byte(c, 8'h31 + 8'(i));
    check("model_crc_check_value", c, 8'hF4);

    // Frame with address and three payload bytes; a frame_start mid-frame must be ignored.
    got_q.delete();
    pay_q = '{8'h37, 8'h38, 8'h39};
    expect_frame(8'h31, 8'h32, 32'h36353433, 1'b1, 3);
    n0 = done_count;
    start_frame(8'h31, 8'h32, 32'h36353433, 1'b1, 7'd3);
    wait_got(5);
    status = 8'hEE; cmd = 8'hDD; data_len = 7'd65; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; data_len = 7'd1;
    @(posedge clk); #1;
    check("busy_start_ready_low", frame_ready, 0);
    wait_done(n0);
    check("frame1_len", got_q.size(), 11);
    for (int i = 0; i < 11; i++) if (i < got_q.size()) check("frame1_literal", got_q[i], lit1[i]);
    check("no_len_error_when_busy", len_err_count, 0);

    // Minimal frame: no address, empty payload.
    got_q.delete();
    expect_frame(8'h00, 8'h00, 32'h0, 1'b0, 0);
    n0 = done_count;
    start_frame(8'h00, 8'h00, 32'h0, 1'b0, 7'd0);
    wait_done(n0);
    check("frame2_len", got_q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < got_q.size()) check("frame2_literal", got_q[i], lit2[i]);

    // Transmitter refuses the STATUS byte for 20 cycles.
    got_q.delete();
    refused = 0;
    pay_q = '{8'hA5, 8'h5A};
    expect_frame(8'h31, 8'h10, 32'h0, 1'b0, 2);
    n0 = done_count;
    start_frame(8'h31, 8'h10, 32'h0, 1'b0, 7'd2);
    wait_got(1);
    cts = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    cts = 1'b1;
    wait_done(n0);
    check("refusals_seen", 32'(refused >= 5), 1);
    check("frame3_len", got_q.size(), 6);

    // Payload withheld for 100 cycles while in FETCH.
    got_q.delete();
    hold_bad = 0;
    pay_q = '{8'hC3, 8'h3C};
    expect_frame(8'h01, 8'h02, 32'hDEADBEEF, 1'b1, 2);
    hold = 100;
    n0 = done_count;
    start_frame(8'h01, 8'h02, 32'hDEADBEEF, 1'b1, 7'd2);
    wait_done(n0);
    check("hold_ready_high_no_start", hold_bad, 0);
    check("hold_elapsed", hold, 0);
    check("frame4_len", got_q.size(), 10);

    // Oversized length from IDLE.
    g0 = got_q.size();
    @(posedge clk); #1;
    data_len = 7'd65; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("len_error_pulse", len_error, 1);
    check("len_error_no_start", tx_start, 0);
    @(posedge clk); #1;
    check("len_error_one_cycle", len_error, 0);
    check("len_error_still_ready", frame_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("len_error_no_bytes", got_q.size(), g0);
    check("len_error_count", len_err_count, 1);

    // Reset while the first ADDR byte is being pulsed.
    got_q.delete();
    pay_q = '{8'h77};
    expect_frame(8'h11, 8'h22, 32'h44332211, 1'b1, 1);
    start_frame(8'h11, 8'h22, 32'h44332211, 1'b1, 7'd1);
    begin
      int t = 0;
      while (!(tx_start && got_q.size() == 3) && t < 500) begin
        @(posedge clk); #1;
        t++;
      end
      check("reached_addr_pulse", 32'(tx_start && got_q.size() == 3), 1);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete(); pay_q.delete(); got_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pay_q = '{8'h77};
    expect_frame(8'h55, 8'hAA, 32'h0, 1'b0, 1);
    n0 = done_count;
    start_frame(8'h55, 8'hAA, 32'h0, 1'b0, 7'd1);
    wait_done(n0);
    check("post_reset_len", got_q.size(), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
